fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl_pkg.sv | 29 ++
 rtl/fifo_rd_ctrl_if.sv | 36 +++
 rtl/fifo_rd_ctrl_rd_skid_buf.sv | 61 ++++++
 rtl/fifo_rd_ctrl.sv | 117 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_ctrl_pkg
// Shared definitions for the FIFO read controller: the burst FSM state type,
// the default word width, the delivered-word counter width, and the helper
// that decides whether another FIFO pop may be issued this cycle.
// ----------------------------------------------------------------------------
package fifo_rd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int WC_W           = 16;

    // A pop may be issued only if the word it returns is guaranteed a slot in
    // the 2-entry output buffer. Words already held plus the word on its way
    // back must leave room, counting a slot freed by a handshake this cycle.
    function automatic logic read_credit(input logic [1:0] buf_count,
                                         input logic       inflight,
                                         input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, buf_count} + {2'b00, inflight};
        return (occ <= 3'd1) || ((occ == 3'd2) && pop);
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// ----------------------------------------------------------------------------
// fifo_rd_ctrl_if
// Groups the FIFO-side read port and the downstream valid/ready stream.
//   master : the read controller (drives fifo_rd_en, m_data, m_valid)
//   slave  : the FIFO + downstream consumer side
// Signals:
//   fifo_rd_en     pop request to the FIFO
//   fifo_empty     FIFO empty flag
//   fifo_underflow FIFO underflow flag
//   fifo_data_out  FIFO read data, valid the cycle after fifo_rd_en
//   m_data/m_valid downstream word and its valid
//   m_ready        downstream accept
// ----------------------------------------------------------------------------
interface fifo_rd_ctrl_if
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF
);
    logic             fifo_rd_en;
    logic             fifo_empty;
    logic             fifo_underflow;
    logic [WIDTH-1:0] fifo_data_out;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output fifo_rd_en, m_data, m_valid,
        input  fifo_empty, fifo_underflow, fifo_data_out, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_data, m_valid,
        output fifo_empty, fifo_underflow, fifo_data_out, m_ready
    );
endinterface

// File: rtl/fifo_rd_ctrl_rd_skid_buf.sv
// ----------------------------------------------------------------------------
// rd_skid_buf
// Two-entry in-order output buffer between the FIFO read data and the
// downstream stream. Push and pop may happen in the same cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (occupancy only)
//   push_i/din_i write a word (the word returned by the previous pop)
//   pop_i        remove the head word (downstream handshake)
//   dout_o       head word; only changes on pop or on a push into empty
//   count_o      number of words held (0..2)
// ----------------------------------------------------------------------------
module rd_skid_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else if (push_i && !pop_i) begin
            count_q <= count_q + 2'd1;
        end else if (!push_i && pop_i) begin
            count_q <= count_q - 2'd1;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (pop_i) begin
            // Tail moves up when two are held; otherwise the incoming word
            // (if any) becomes the new head.
            head_q <= (count_q == 2'd2) ? tail_q : din_i;
            if (push_i && (count_q == 2'd2)) begin
                tail_q <= din_i;
            end
        end else if (push_i) begin
            if (count_q == 2'd0) begin
                head_q <= din_i;
            end else begin
                tail_q <= din_i;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push_i && !pop_i && (count_q == 2'd2)));

    assign dout_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_rd_ctrl
// Pops bursts of up to BURST_LEN words from a FIFO with one-cycle read
// latency and forwards them on a valid/ready stream at up to 1 word/cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         permission to start a new burst (never aborts one)
//   bus (master)   FIFO read port and downstream stream
//   burst_done     one-cycle pulse when a burst has fully drained
//   word_count     downstream handshakes, wraps at 16 bits
//   underflow_err  sticky FIFO underflow flag, cleared only by reset
// ----------------------------------------------------------------------------
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int BURST_LEN  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    fifo_rd_ctrl_if.master  bus,
    output logic            burst_done,
    output logic [WC_W-1:0] word_count,
    output logic            underflow_err
);
    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    state_e                state_q, state_d;
    logic [7:0]            issued_q, issued_d;
    logic                  inflight_q;
    logic [WC_W-1:0]       wc_q;
    logic                  uerr_q;

    logic [1:0]            buf_count;
    logic [FIFO_WIDTH-1:0] head_data;
    logic                  m_valid;
    logic                  pop;
    logic                  rd_en;

    assign m_valid = (buf_count != 2'd0);
    assign pop     = m_valid && bus.m_ready;

    assign rd_en = (state_q == READ) && !bus.fifo_empty &&
                   (issued_q < BURST_MAX) &&
                   read_credit(buf_count, inflight_q, pop);

    rd_skid_buf #(
        .W (FIFO_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   (bus.fifo_data_out),
        .pop_i   (pop),
        .dout_o  (head_data),
        .count_o (buf_count)
    );

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        burst_done = 1'b0;
        if (rd_en) begin
            issued_d = issued_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                if (enable && !bus.fifo_empty) begin
                    state_d  = READ;
                    issued_d = 8'd0;
                end
            end
            READ: begin
                // Full burst issued, or the FIFO ran dry after at least one pop.
                if ((issued_q == BURST_MAX) ||
                    (bus.fifo_empty && (issued_q != 8'd0))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((buf_count == 2'd0) && !inflight_q) begin
                    state_d    = IDLE;
                    burst_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            issued_q   <= 8'd0;
            inflight_q <= 1'b0;
            wc_q       <= '0;
            uerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            inflight_q <= rd_en;
            if (pop) begin
                wc_q <= wc_q + 1'b1;
            end
            if (bus.fifo_underflow) begin
                uerr_q <= 1'b1;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = head_data;
    assign word_count     = wc_q;
    assign underflow_err  = uerr_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;
    import fifo_rd_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic enable2 = 1'b0;
    logic burst_done, burst_done2;
    logic [15:0] word_count, word_count2;
    logic underflow_err, underflow_err2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.WIDTH(16)) bus ();
    fifo_rd_ctrl_if #(.WIDTH(16)) bus2 ();

    fifo_rd_ctrl #(.FIFO_WIDTH(16), .BURST_LEN(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .bus           (bus),
        .burst_done    (burst_done),
        .word_count    (word_count),
        .underflow_err (underflow_err)
    );

    // Second instance with long bursts, used only for the counter wrap run.
    fifo_rd_ctrl #(.FIFO_WIDTH(16), .BURST_LEN(255)) u_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable2),
        .bus           (bus2),
        .burst_done    (burst_done2),
        .word_count    (word_count2),
        .underflow_err (underflow_err2)
    );

    // FIFO model: one-cycle read latency, 16 entries.
    logic [15:0] mem [16];
    logic [3:0]  rd_ptr = 4'd0;
    logic [3:0]  wr_ptr = 4'd0;
    logic [15:0] fifo_q;

    assign bus.fifo_empty    = (rd_ptr == wr_ptr);
    assign bus.fifo_data_out = fifo_q;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
        end
    end

    // Endless source for the wrap instance.
    assign bus2.fifo_empty     = 1'b0;
    assign bus2.fifo_data_out  = 16'h0;
    assign bus2.fifo_underflow = 1'b0;
    assign bus2.m_ready        = 1'b1;

    int hs2 = 0;
    always @(posedge clk) begin
        if (!rst_n) hs2 <= 0;
        else if (bus2.m_valid && bus2.m_ready) hs2 <= hs2 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        bus.m_ready = 1'b0;
        bus.fifo_underflow = 1'b0;
        wr_ptr = rd_ptr;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rd_en;
        logic        vld;
        logic [15:0] data;
        logic        done;
    } vec_t;

    vec_t tv [9];

    initial begin
        int rd_cnt;
        int hs;
        int done_cnt;
        int done_cyc;
        int hs2_cyc;
        int stable_bad;
        int c;
        logic [15:0] got [8];
        logic [15:0] dmask;

        // en rdy | rd_en vld data done: 4-word burst, full throughput
        tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b0};
        tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h2222, 1'b0};
        tv[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h3333, 1'b0};
        tv[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h4444, 1'b0};
        tv[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tv[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

        bus.m_ready = 1'b0;
        bus.fifo_underflow = 1'b0;

        // Reset state
        #2;
        chk("rst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_burst_done", {31'd0, burst_done}, 32'd0);
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        chk("rst_underflow_err", {31'd0, underflow_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full burst, table driven
        push_word(16'h1111); push_word(16'h2222);
        push_word(16'h3333); push_word(16'h4444);
        for (int i = 0; i < 9; i++) begin
            enable = tv[i].en;
            bus.m_ready = tv[i].rdy;
            @(negedge clk);
            dmask = tv[i].vld ? bus.m_data : 16'h0;
            chk($sformatf("burst4_cyc%0d", i),
                {13'd0, bus.fifo_rd_en, bus.m_valid, burst_done, dmask},
                {13'd0, tv[i].rd_en, tv[i].vld, tv[i].done, tv[i].data});
            tick();
        end
        chk("burst4_word_count", {16'd0, word_count}, 32'd4);

        // Short burst: only 2 words available
        do_reset();
        push_word(16'h00A1); push_word(16'h00A2);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        rd_cnt = 0; hs = 0; done_cnt = 0; done_cyc = -1; hs2_cyc = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.m_valid && bus.m_ready) begin
                if (hs < 8) got[hs] = bus.m_data;
                hs++;
                if (hs == 2) hs2_cyc = k;
            end
            if (burst_done) begin
                done_cnt++;
                done_cyc = k;
            end
            tick();
        end
        chk("short_rd_cnt", rd_cnt, 32'd2);
        chk("short_hs_cnt", hs, 32'd2);
        chk("short_word0", {16'd0, got[0]}, 32'h00A1);
        chk("short_word1", {16'd0, got[1]}, 32'h00A2);
        chk("short_done_cnt", done_cnt, 32'd1);
        chk("short_done_after_hs2", done_cyc, hs2_cyc + 1);

        // Back-pressure: 8 words, m_ready low 10+ cycles, enable dropped
        do_reset();
        for (int k = 0; k < 8; k++) push_word(16'h1000 + 16'(k));
        enable = 1'b1;
        bus.m_ready = 1'b0;
        tick();
        enable = 1'b0;
        rd_cnt = 0; stable_bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rd_cnt++;
            if (k >= 2 && !(bus.m_valid && bus.m_data == 16'h1000)) stable_bad++;
            tick();
        end
        chk("bp_rd_cnt_stalled", rd_cnt, 32'd2);
        chk("bp_head_stable", stable_bad, 32'd0);
        bus.m_ready = 1'b1;
        hs = 0; done_cnt = 0;
        for (c = 0; c < 20 && done_cnt == 0; c++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rd_cnt++;
            if (bus.m_valid && bus.m_ready) begin
                if (hs < 8) got[hs] = bus.m_data;
                hs++;
            end
            if (burst_done) done_cnt++;
            tick();
        end
        chk("bp_done_seen", done_cnt, 32'd1);
        chk("bp_rd_cnt_total", rd_cnt, 32'd4);
        chk("bp_hs_cnt", hs, 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_word%0d", k), {16'd0, got[k]}, 32'h1000 + k);
        rd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.fifo_rd_en || bus.m_valid) rd_cnt++;
            tick();
        end
        chk("bp_no_new_burst_enable_low", rd_cnt, 32'd0);
        chk("bp_word_count", {16'd0, word_count}, 32'd4);

        // Sticky underflow
        bus.fifo_underflow = 1'b1;
        tick();
        bus.fifo_underflow = 1'b0;
        @(negedge clk);
        chk("uflow_set", {31'd0, underflow_err}, 32'd1);
        repeat (5) tick();
        @(negedge clk);
        chk("uflow_sticky", {31'd0, underflow_err}, 32'd1);
        tick();

        // Asynchronous reset with two words buffered
        enable = 1'b1;
        bus.m_ready = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("midrst_pre_valid", {31'd0, bus.m_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("midrst_word_count", {16'd0, word_count}, 32'd0);
        chk("midrst_underflow_err", {31'd0, underflow_err}, 32'd0);
        chk("midrst_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
        enable = 1'b0;
        wr_ptr = rd_ptr;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (burst_done || bus.m_valid) done_cnt++;
            tick();
        end
        chk("midrst_no_done", done_cnt, 32'd0);

        // word_count wrap after 65536 handshakes
        enable2 = 1'b1;
        for (c = 0; c < 70000 && hs2 < 65535; c++) @(negedge clk);
        chk("wrap_reach_65535", hs2, 32'd65535);
        chk("wrap_ffff", {16'd0, word_count2}, 32'h0000FFFF);
        for (c = 0; c < 10 && hs2 < 65536; c++) @(negedge clk);
        chk("wrap_reach_65536", hs2, 32'd65536);
        chk("wrap_zero", {16'd0, word_count2}, 32'd0);
        enable2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
